// File: rtl/hash_msg_feeder_if.sv
// Bundle of the host write, hash-core and digest-return signals around hash_msg_feeder.
// Handshake rule for the valid/ready pairs (wr_*, dig_*): a transfer happens on a rising
// clk edge where valid and ready are both 1. Once asserted, valid holds its payload until then.
interface hash_msg_feeder_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic        wr_last;
  logic        M_valid;
  logic [7:0]  M;
  logic [63:0] input_lenght;
  logic        hash_ready;
  logic [31:0] digest;
  logic        dig_valid;
  logic        dig_ready;
  logic [31:0] dig_data;
  logic        dig_trunc;
  logic        busy;

  modport slave (
    input  wr_valid, wr_data, wr_last, hash_ready, digest, dig_ready,
    output wr_ready, M_valid, M, input_lenght, dig_valid, dig_data, dig_trunc, busy
  );

  modport master (
    output wr_valid, wr_data, wr_last, hash_ready, digest, dig_ready,
    input  wr_ready, M_valid, M, input_lenght, dig_valid, dig_data, dig_trunc, busy
  );
endinterface

// File: rtl/hash_msg_feeder.sv
// Buffers one host message, streams it into lightHashDES and returns the captured digest.
// Optional macro HASH_FEEDER_TIMEOUT_EN adds a WAIT_HASH timeout and the timeout_err output.
module hash_msg_feeder #(
    parameter int DEPTH       = 4096,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             reset,
    hash_msg_feeder_if.slave bus,
`ifdef HASH_FEEDER_TIMEOUT_EN
    output logic             timeout_err,
`endif
    output logic [1:0]       state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   count;
    logic [CW-1:0]   len;
    logic [CW-1:0]   idx;
    logic            trunc;
    logic            dig_valid_q;
    logic [31:0]     dig_data_q;
    logic            dig_trunc_q;
    logic [7:0]      mem [DEPTH];
    logic [7:0]      rd_q;
    logic [AW-1:0]   rd_addr;
    logic            accept;
    logic            last_byte;
    logic            stream_done;
    logic            timeout_hit;

    assign accept      = bus.wr_valid && (state == S_LOAD);
    assign last_byte   = bus.wr_last || (count == CW'(DEPTH - 1));
    // idx counts bytes already presented on M, so the final byte is on M when idx == len.
    assign stream_done = (idx == len);
    assign rd_addr     = (state == S_STREAM) ? idx[AW-1:0] : '0;

`ifdef HASH_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;
    logic          timeout_q;

    assign timeout_hit = (tcnt == TW'(TIMEOUT_CYC - 1));
    assign timeout_err = timeout_q;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:   if (accept && last_byte)             state_nxt = S_STREAM;
            S_STREAM: if (stream_done)                     state_nxt = S_WAIT;
            S_WAIT:   if (bus.hash_ready || timeout_hit)   state_nxt = S_HOLD;
            S_HOLD:   if (bus.dig_ready)                   state_nxt = S_LOAD;
            default:                                       state_nxt = S_LOAD;
        endcase
    end

    // Write-first buffer read: byte 0 may be written in the same cycle it is needed on M.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[count[AW-1:0]] <= bus.wr_data;
        end
        if (accept && (count[AW-1:0] == rd_addr)) begin
            rd_q <= bus.wr_data;
        end else begin
            rd_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            len         <= '0;
            idx         <= '0;
            trunc       <= 1'b0;
            dig_valid_q <= 1'b0;
            dig_data_q  <= '0;
            dig_trunc_q <= 1'b0;
`ifdef HASH_FEEDER_TIMEOUT_EN
            tcnt        <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
`ifdef HASH_FEEDER_TIMEOUT_EN
            tcnt <= '0;
`endif
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        count <= count + CW'(1);
                        if (last_byte) begin
                            len   <= count + CW'(1);
                            trunc <= !bus.wr_last;
                            idx   <= CW'(1);
                        end
                    end
                end
                S_STREAM: begin
                    if (!stream_done) begin
                        idx <= idx + CW'(1);
                    end
                end
                S_WAIT: begin
`ifdef HASH_FEEDER_TIMEOUT_EN
                    tcnt <= tcnt + TW'(1);
`endif
                    if (bus.hash_ready) begin
                        dig_valid_q <= 1'b1;
                        dig_data_q  <= bus.digest;
                        dig_trunc_q <= trunc;
                    end else if (timeout_hit) begin
                        dig_valid_q <= 1'b1;
                        dig_data_q  <= 32'hDEAD_DEAD;
                        dig_trunc_q <= trunc;
`ifdef HASH_FEEDER_TIMEOUT_EN
                        timeout_q   <= 1'b1;
`endif
                    end
                end
                S_HOLD: begin
                    if (bus.dig_ready) begin
                        dig_valid_q <= 1'b0;
                        count       <= '0;
                        trunc       <= 1'b0;
`ifdef HASH_FEEDER_TIMEOUT_EN
                        timeout_q   <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.wr_ready     = (state == S_LOAD);
    assign bus.M_valid      = (state == S_STREAM);
    assign bus.M            = (state == S_STREAM) ? rd_q : 8'd0;
    assign bus.input_lenght = 64'(len);
    assign bus.dig_valid    = dig_valid_q;
    assign bus.dig_data     = dig_data_q;
    assign bus.dig_trunc    = dig_trunc_q;
    assign bus.busy         = !((state == S_LOAD) && (count == '0));
    assign state_dbg        = state;

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Directed bench for hash_msg_feeder: a DEPTH=4096 instance (a) and a DEPTH=16 instance (b).
module tb_hash_msg_feeder;

  localparam int DEPTH_A = 4096;
  localparam int DEPTH_B = 16;
  localparam int TMO     = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hash_msg_feeder_if if_a ();
  hash_msg_feeder_if if_b ();
  logic [1:0] dbg_a;
  logic [1:0] dbg_b;
`ifdef HASH_FEEDER_TIMEOUT_EN
  logic tmo_a;
  logic tmo_b;
`endif

  hash_msg_feeder #(.DEPTH(DEPTH_A), .TIMEOUT_CYC(TMO)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a),
`ifdef HASH_FEEDER_TIMEOUT_EN
    .timeout_err(tmo_a),
`endif
    .state_dbg(dbg_a)
  );

  hash_msg_feeder #(.DEPTH(DEPTH_B), .TIMEOUT_CYC(TMO)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b),
`ifdef HASH_FEEDER_TIMEOUT_EN
    .timeout_err(tmo_b),
`endif
    .state_dbg(dbg_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: expected M bytes per instance, plus run-length of M_valid bursts
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int run_a = 0, last_a = 0;
  int run_b = 0, last_b = 0;

  always @(negedge clk) begin
    if (reset) begin
      run_a = 0;
    end else if (if_a.M_valid) begin
      run_a++;
      if (exp_a.size() == 0) check("a_m_extra", if_a.M_valid, 1'b0);
      else check("a_m_byte", if_a.M, exp_a.pop_front());
    end else if (run_a != 0) begin
      last_a = run_a;
      run_a = 0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      run_b = 0;
    end else if (if_b.M_valid) begin
      run_b++;
      if (exp_b.size() == 0) check("b_m_extra", if_b.M_valid, 1'b0);
      else check("b_m_byte", if_b.M, exp_b.pop_front());
    end else if (run_b != 0) begin
      last_b = run_b;
      run_b = 0;
    end
  end

  // driver tasks
  task automatic drive_wr(input bit sel, input logic v, input logic [7:0] d, input logic l);
    if (sel) begin
      if_b.wr_valid = v; if_b.wr_data = d; if_b.wr_last = l;
    end else begin
      if_a.wr_valid = v; if_a.wr_data = d; if_a.wr_last = l;
    end
  endtask

  task automatic set_hash(input bit sel, input logic hr, input logic [31:0] dg);
    if (sel) begin
      if_b.hash_ready = hr; if_b.digest = dg;
    end else begin
      if_a.hash_ready = hr; if_a.digest = dg;
    end
  endtask

  task automatic set_dready(input bit sel, input logic r);
    if (sel) if_b.dig_ready = r;
    else if_a.dig_ready = r;
  endtask

  // Returns one cycle after the last accepting edge, i.e. in the first STREAM cycle.
  task automatic push_msg(input bit sel, input int n, input logic [7:0] start,
                          input bit last, input int bound, output int acc);
    logic [7:0] d;
    logic       rdy;
    bit         done;
    int         w;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      d = start + 8'(i);
      drive_wr(sel, 1'b1, d, last && (i == n - 1));
      done = 0;
      w = 0;
      while (!done && w < bound) begin
        rdy = sel ? if_b.wr_ready : if_a.wr_ready;
        @(posedge clk); #1;
        w++;
        if (rdy) begin
          done = 1;
          acc++;
          if (sel) exp_b.push_back(d);
          else exp_a.push_back(d);
        end
      end
      if (!done) break;
    end
    drive_wr(sel, 1'b0, 8'h00, 1'b0);
  endtask

  // From the first STREAM cycle, land just after the negedge of the first WAIT_HASH cycle.
  task automatic wait_stream(input int remaining);
    repeat (remaining) @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic give_hash(input bit sel, input logic [31:0] dg);
    set_hash(sel, 1'b1, dg);
    @(posedge clk); #1;
    set_hash(sel, 1'b0, 32'h0);
  endtask

  task automatic take_digest(input bit sel);
    set_dready(sel, 1'b1);
    @(posedge clk); #1;
    set_dready(sel, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int acc;

  initial begin
    reset = 1'b1;
    drive_wr(0, 1'b0, 8'h00, 1'b0);
    drive_wr(1, 1'b0, 8'h00, 1'b0);
    set_hash(0, 1'b0, 32'h0);
    set_hash(1, 1'b0, 32'h0);
    set_dready(0, 1'b0);
    set_dready(1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_ready",  if_a.wr_ready, 1'b1);
    check("rst_m_valid",   if_a.M_valid, 1'b0);
    check("rst_m",         if_a.M, 8'h00);
    check("rst_len",       if_a.input_lenght, 64'd0);
    check("rst_dig_valid", if_a.dig_valid, 1'b0);
    check("rst_dig_data",  if_a.dig_data, 32'h0);
    check("rst_dig_trunc", if_a.dig_trunc, 1'b0);
    check("rst_busy",      if_a.busy, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 3000-byte message, i mod 256
    push_msg(0, 3000, 8'h00, 1'b1, 4, acc);
    check("big_acc", acc, 3000);
    check("big_len_early", if_a.input_lenght, 64'd3000);
    check("big_busy", if_a.busy, 1'b1);
    wait_stream(3000);
    check("big_run", last_a, 3000);
    check("big_sb_empty", exp_a.size(), 0);
    check("big_mv_off", if_a.M_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("big_no_dig_early", if_a.dig_valid, 1'b0);
    give_hash(0, 32'h1234_5678);
    check("big_dig_valid", if_a.dig_valid, 1'b1);
    check("big_dig_data", if_a.dig_data, 32'h1234_5678);
    check("big_dig_trunc", if_a.dig_trunc, 1'b0);

    // digest held 50 cycles without dig_ready
    repeat (50) @(posedge clk);
    #1;
    check("hold_dig_valid", if_a.dig_valid, 1'b1);
    check("hold_dig_data", if_a.dig_data, 32'h1234_5678);
    check("hold_wr_ready", if_a.wr_ready, 1'b0);
    check("hold_m_valid", if_a.M_valid, 1'b0);
    take_digest(0);
    check("hs_wr_ready", if_a.wr_ready, 1'b1);
    check("hs_dig_valid", if_a.dig_valid, 1'b0);
    check("hs_busy", if_a.busy, 1'b0);

    // single-byte message
    push_msg(0, 1, 8'hA5, 1'b1, 4, acc);
    check("one_acc", acc, 1);
    check("one_m_valid", if_a.M_valid, 1'b1);
    check("one_m", if_a.M, 8'hA5);
    check("one_len", if_a.input_lenght, 64'd1);
    wait_stream(1);
    check("one_run", last_a, 1);
    give_hash(0, 32'hCAFE_F00D);
    check("one_dig_data", if_a.dig_data, 32'hCAFE_F00D);
    take_digest(0);
    check("one_wr_ready", if_a.wr_ready, 1'b1);

    // reset in the middle of a 3000-byte stream
    push_msg(0, 3000, 8'h00, 1'b1, 4, acc);
    repeat (100) @(posedge clk);
    #1;
    check("mid_m_byte100", if_a.M, 8'd100);
    reset = 1'b1;
    #1;
    check("mid_rst_m_valid", if_a.M_valid, 1'b0);
    check("mid_rst_m", if_a.M, 8'h00);
    check("mid_rst_wr_ready", if_a.wr_ready, 1'b1);
    check("mid_rst_len", if_a.input_lenght, 64'd0);
    check("mid_rst_busy", if_a.busy, 1'b0);
    check("mid_rst_dig_valid", if_a.dig_valid, 1'b0);
    exp_a.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // 5-byte message; stale hash_ready pulse during STREAM must be ignored
    push_msg(0, 5, 8'h30, 1'b1, 4, acc);
    check("five_acc", acc, 5);
    set_hash(0, 1'b1, 32'h0BAD_0BAD);
    @(posedge clk); #1;
    set_hash(0, 1'b0, 32'h0);
    wait_stream(4);
    check("five_run", last_a, 5);
    check("five_len", if_a.input_lenght, 64'd5);
    check("five_stale_hash", if_a.dig_valid, 1'b0);
    give_hash(0, 32'h0000_5555);
    check("five_dig_data", if_a.dig_data, 32'h0000_5555);
    take_digest(0);
    check("five_sb_empty", exp_a.size(), 0);

    // DEPTH=16: 16 bytes without wr_last, further host byte held valid and blocked
    push_msg(1, 16, 8'h80, 1'b0, 4, acc);
    check("tr_acc", acc, 16);
    check("tr_wr_ready", if_b.wr_ready, 1'b0);
    check("tr_len", if_b.input_lenght, 64'd16);
    drive_wr(1, 1'b1, 8'h90, 1'b0);
    wait_stream(16);
    check("tr_run", last_b, 16);
    check("tr_still_blocked", if_b.wr_ready, 1'b0);
    give_hash(1, 32'h7777_1616);
    check("tr_dig_valid", if_b.dig_valid, 1'b1);
    check("tr_dig_trunc", if_b.dig_trunc, 1'b1);
    check("tr_dig_data", if_b.dig_data, 32'h7777_1616);
    drive_wr(1, 1'b0, 8'h00, 1'b0);
    take_digest(1);
    check("tr_sb_empty", exp_b.size(), 0);
    check("tr_wr_ready_back", if_b.wr_ready, 1'b1);

    // hash_ready never arrives
    push_msg(1, 2, 8'h11, 1'b1, 4, acc);
    check("to_acc", acc, 2);
    wait_stream(2);
`ifdef HASH_FEEDER_TIMEOUT_EN
    repeat (TMO - 1) @(posedge clk);
    #1;
    check("to_not_yet", if_b.dig_valid, 1'b0);
    @(posedge clk); #1;
    check("to_dig_valid", if_b.dig_valid, 1'b1);
    check("to_dig_data", if_b.dig_data, 32'hDEAD_DEAD);
    check("to_err", tmo_b, 1'b1);
    check("to_trunc", if_b.dig_trunc, 1'b0);
    take_digest(1);
    check("to_err_clr", tmo_b, 1'b0);
`else
    repeat (20) @(posedge clk);
    #1;
    check("nt_still_waiting", if_b.dig_valid, 1'b0);
    give_hash(1, 32'h2222_0002);
    check("nt_dig_data", if_b.dig_data, 32'h2222_0002);
    check("nt_dig_trunc", if_b.dig_trunc, 1'b0);
    take_digest(1);
`endif
    check("b_final_busy", if_b.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
